// File: rtl/ypbpr_mode_ctrl.sv
// -----------------------------------------------------------------------------
// ypbpr_mode_ctrl
//
// Output-mode controller for the RGB-to-YPbPr converter. It takes a mode
// request from the OSD/config logic and applies it only at a vertical sync
// boundary. After the switch the video stays blanked for a programmable number
// of whole frames, so a display never sees a torn or half-converted frame.
// The block never touches pixel data.
//
// Parameters
//   MUTE_FRAMES   : vsync rising edges the output stays blanked after a switch
//                   (0..15). The power-on mute uses the same count.
//   TO_BITS       : width of the vsync watchdog. A pending switch is forced
//                   when the watchdog reaches all ones.
//   VS_ACTIVE_LOW : 1 = vs_in is active-low and is inverted before edge
//                   detection.
//
// Ports
//   clk          in   video clock
//   reset        in   asynchronous, active-high reset
//   mode_req     in   requested mode, 1 = YPbPr, 0 = RGB (asynchronous to clk)
//   vs_in        in   vertical sync from the timing generator
//   conv_ena     out  converter enable, 1 = YPbPr conversion, 0 = passthrough
//   blank        out  1 forces downstream video to black
//   cs_sel       out  1 selects composite sync on the hsync output
//   mode_active  out  mode currently applied
//   busy         out  1 while a switch is pending or the mute is running
//   dbg_state_o  out  current controller state (STABLE=0, WAIT_VS=1, MUTE=2)
//
// Optional feature, macro YPBPR_MODE_CTRL_SOG_EN:
//   cs_in        in   composite sync
//   sog          out  registered (cs_in & mode_active & ~blank), the
//                     sync-on-green/luma enable for the analog DAC
//
// All outputs are registered; no input reaches an output combinationally.
// -----------------------------------------------------------------------------
module ypbpr_mode_ctrl #(
    parameter int MUTE_FRAMES   = 2,
    parameter int TO_BITS       = 22,
    parameter bit VS_ACTIVE_LOW = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       mode_req,
    input  logic       vs_in,
`ifdef YPBPR_MODE_CTRL_SOG_EN
    input  logic       cs_in,
    output logic       sog,
`endif
    output logic       conv_ena,
    output logic       blank,
    output logic       cs_sel,
    output logic       mode_active,
    output logic       busy,
    output logic [1:0] dbg_state_o
);

    typedef enum logic [1:0] {
        ST_STABLE  = 2'd0,
        ST_WAIT_VS = 2'd1,
        ST_MUTE    = 2'd2
    } state_t;

    localparam logic [3:0] MUTE_INIT = 4'(MUTE_FRAMES);

    // ---------------------------------------------------------------------
    // Registers
    // ---------------------------------------------------------------------
    state_t               state_q, state_d;
    logic                 sync1_q;
    logic                 sync2_q;
    logic                 vs_d_q;
    logic [TO_BITS-1:0]   wd_q, wd_d;
    logic [3:0]           mute_cnt_q, mute_cnt_d;
    logic                 blank_q, blank_d;
    logic                 busy_q, busy_d;
    logic                 mode_active_q, mode_active_d;
    logic                 conv_ena_q, conv_ena_d;
    logic                 cs_sel_q, cs_sel_d;

    // ---------------------------------------------------------------------
    // Derived conditions
    // ---------------------------------------------------------------------
    logic mode_s;
    logic vs_n;
    logic vs_rise;
    logic wd_full;
    logic mismatch;
    logic switch_now;
    logic mute_done;

    assign mode_s   = sync2_q;
    assign vs_n     = VS_ACTIVE_LOW ? ~vs_in : vs_in;
    // vs_d_q always tracks vs_n, so a rise that lands on the WAIT_VS entry
    // edge is already consumed when WAIT_VS starts looking at vs_rise.
    assign vs_rise  = vs_n & ~vs_d_q;
    assign wd_full  = &wd_q;
    assign mismatch = (mode_s != mode_active_q);

    // Withdrawal (no mismatch) wins over a coincident vsync or timeout.
    assign switch_now = (state_q == ST_WAIT_VS) && mismatch && (vs_rise || wd_full);

    // Mute ends either immediately (count already zero) or on the vsync edge
    // that takes the count from 1 to 0.
    assign mute_done  = (state_q == ST_MUTE) &&
                        ((mute_cnt_q == 4'd0) || (vs_rise && (mute_cnt_q == 4'd1)));

    // ---------------------------------------------------------------------
    // Process 1: state and output registers
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_MUTE;
            sync1_q       <= 1'b0;
            sync2_q       <= 1'b0;
            vs_d_q        <= 1'b0;
            wd_q          <= '0;
            mute_cnt_q    <= MUTE_INIT;
            blank_q       <= 1'b1;
            busy_q        <= 1'b1;
            mode_active_q <= 1'b0;
            conv_ena_q    <= 1'b0;
            cs_sel_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            sync1_q       <= mode_req;
            sync2_q       <= sync1_q;
            vs_d_q        <= vs_n;
            wd_q          <= wd_d;
            mute_cnt_q    <= mute_cnt_d;
            blank_q       <= blank_d;
            busy_q        <= busy_d;
            mode_active_q <= mode_active_d;
            conv_ena_q    <= conv_ena_d;
            cs_sel_q      <= cs_sel_d;
        end
    end

    // ---------------------------------------------------------------------
    // Process 2: next state, watchdog and mute counter
    // ---------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        wd_d       = wd_q;
        mute_cnt_d = mute_cnt_q;

        case (state_q)
            ST_STABLE: begin
                if (mismatch) begin
                    state_d = ST_WAIT_VS;
                    wd_d    = '0;
                end
            end

            ST_WAIT_VS: begin
                // Saturating; cleared again on every WAIT_VS entry.
                if (!wd_full) begin
                    wd_d = wd_q + TO_BITS'(1);
                end
                if (!mismatch) begin
                    state_d = ST_STABLE;
                end else if (vs_rise || wd_full) begin
                    state_d    = ST_MUTE;
                    mute_cnt_d = MUTE_INIT;
                end
            end

            ST_MUTE: begin
                if (mute_cnt_q == 4'd0) begin
                    state_d = ST_STABLE;
                end else if (vs_rise) begin
                    mute_cnt_d = mute_cnt_q - 4'd1;
                    if (mute_cnt_q == 4'd1) begin
                        state_d = ST_STABLE;
                    end
                end
            end

            default: begin
                state_d = ST_STABLE;
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // Process 3: next values of the registered outputs
    // ---------------------------------------------------------------------
    always_comb begin
        blank_d       = blank_q;
        busy_d        = busy_q;
        mode_active_d = mode_active_q;
        conv_ena_d    = conv_ena_q;
        cs_sel_d      = cs_sel_q;

        case (state_q)
            ST_STABLE: begin
                blank_d = 1'b0;
                busy_d  = mismatch;
            end

            ST_WAIT_VS: begin
                if (!mismatch) begin
                    busy_d = 1'b0;
                end else if (switch_now) begin
                    // Converter, sync select and reported mode all change on
                    // the same edge that starts the mute.
                    mode_active_d = mode_s;
                    conv_ena_d    = mode_s;
                    cs_sel_d      = mode_s;
                    blank_d       = 1'b1;
                end
            end

            ST_MUTE: begin
                if (mute_done) begin
                    blank_d = 1'b0;
                    busy_d  = 1'b0;
                end
            end

            default: begin
                blank_d = 1'b1;
                busy_d  = 1'b1;
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // Outputs
    // ---------------------------------------------------------------------
    assign conv_ena    = conv_ena_q;
    assign blank       = blank_q;
    assign cs_sel      = cs_sel_q;
    assign mode_active = mode_active_q;
    assign busy        = busy_q;
    assign dbg_state_o = state_q;

`ifdef YPBPR_MODE_CTRL_SOG_EN
    // Sync-on-green only while YPbPr is applied and the picture is visible.
    logic sog_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sog_q <= 1'b0;
        end else begin
            sog_q <= cs_in & mode_active_q & ~blank_q;
        end
    end

    assign sog = sog_q;
`else
    // No sync-on-green path in this build.
`endif

endmodule

// File: tb/tb_ypbpr_mode_ctrl.sv
// -----------------------------------------------------------------------------
// tb_ypbpr_mode_ctrl
//
// Self-checking bench for ypbpr_mode_ctrl. Vsync is generated from a simple
// schedule (first rise at vs_base, then every vs_period edges, 3 edges high),
// so every rise edge is known in advance. Each scenario predicts, from the
// request time and the rise schedule, the edges at which busy rises, the mode
// switches, and the mute ends, and compares all outputs every clock.
// Outputs are sampled 1 time unit after the rising clock edge.
// -----------------------------------------------------------------------------
module tb_ypbpr_mode_ctrl;

    localparam int MUTE_FRAMES = 2;
    localparam int TO_BITS     = 8;
    localparam int WD_SPAN     = 1 << TO_BITS;

    // ---------------------------------------------------------------------
    // Clock / reset / DUT
    // ---------------------------------------------------------------------
    logic       clk      = 1'b0;
    logic       reset    = 1'b0;
    logic       mode_req = 1'b0;
    logic       vs_in    = 1'b0;
    logic       conv_ena, blank, cs_sel, mode_active, busy;
    logic [1:0] dbg_state;
    logic [4:0] obs;
`ifdef YPBPR_MODE_CTRL_SOG_EN
    logic       cs_in = 1'b0;
    logic       sog;
    logic       sog_q[$];
`endif

    always #5 clk = ~clk;

    ypbpr_mode_ctrl #(
        .MUTE_FRAMES  (MUTE_FRAMES),
        .TO_BITS      (TO_BITS),
        .VS_ACTIVE_LOW(1'b0)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .mode_req   (mode_req),
        .vs_in      (vs_in),
`ifdef YPBPR_MODE_CTRL_SOG_EN
        .cs_in      (cs_in),
        .sog        (sog),
`endif
        .conv_ena   (conv_ena),
        .blank      (blank),
        .cs_sel     (cs_sel),
        .mode_active(mode_active),
        .busy       (busy),
        .dbg_state_o(dbg_state)
    );

    assign obs = {busy, blank, mode_active, conv_ena, cs_sel};

    // ---------------------------------------------------------------------
    // Bench state
    // ---------------------------------------------------------------------
    int         n         = 0;     // rising edges so far
    int         checks    = 0;
    int         errors    = 0;
    bit         exp_mode  = 1'b0;  // mode the model says is applied
    bit         vs_on     = 1'b0;
    int         vs_base   = 0;
    int         vs_period = 1000;
    logic [4:0] exp_q[$];

    function automatic bit vs_level(int e);
        return vs_on && (e >= vs_base) && (((e - vs_base) % vs_period) < 3);
    endfunction

    // First scheduled vsync rise strictly after edge 'after'.
    function automatic int next_rise(int after);
        if (after < vs_base) return vs_base;
        return vs_base + ((after - vs_base) / vs_period + 1) * vs_period;
    endfunction

    // Expected {busy, blank, mode_active, conv_ena, cs_sel}.
    function automatic logic [4:0] vec(bit b, bit bl, bit m);
        return {b, bl, m, m, m};
    endfunction

    // ---------------------------------------------------------------------
    // Driver tasks
    // ---------------------------------------------------------------------
    task automatic step();
        vs_in = vs_level(n + 1);
        @(posedge clk);
        #1;
        n++;
    endtask

    // New vsync schedule; the line is low until the first rise.
    task automatic vs_restart(int p);
        vs_period = p;
        vs_base   = n + 4 + $urandom_range(0, p);
        vs_on     = 1'b1;
    endtask

    // ---------------------------------------------------------------------
    // Scenarios
    // ---------------------------------------------------------------------
    task automatic test_reset();
        int         u0;
        logic [4:0] exp;
        reset    = 1'b1;
        mode_req = 1'b0;
        vs_on    = 1'b0;
        repeat (3) begin
            step();
            checks++;
            if (obs !== vec(1, 1, 0)) begin
                errors++;
                $display("FAIL reset_hold n=%0d got %b want %b", n, obs, vec(1, 1, 0));
            end
        end
        vs_restart(1000);
        reset = 1'b0;
        // Power-on mute ends on the MUTE_FRAMES-th rise.
        u0 = vs_base + (MUTE_FRAMES - 1) * vs_period;
        while (n < u0 + 5) begin
            step();
            exp = (n < u0) ? vec(1, 1, 0) : vec(0, 0, 0);
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL power_on_mute n=%0d got %b want %b", n, obs, exp);
            end
        end
        exp_mode = 1'b0;
    endtask

    task automatic test_switch(bit coincide);
        int         p, k, t0, e, s, u;
        bit         m0, m1;
        logic [4:0] exp;
        m0 = exp_mode;
        m1 = ~m0;
        p  = $urandom_range(20, 80);
        vs_restart(p);
        // In the coincident case the WAIT_VS entry edge is itself a rise.
        if (coincide) k = next_rise(n + 4) - 3 - n;
        else          k = $urandom_range(1, 2 * p);
        repeat (k) begin
            step();
            checks++;
            if (obs !== vec(0, 0, m0)) begin
                errors++;
                $display("FAIL switch_idle n=%0d got %b want %b", n, obs, vec(0, 0, m0));
            end
        end
        t0       = n;
        mode_req = m1;
        e        = t0 + 3;
        s        = next_rise(e);
        u        = s + MUTE_FRAMES * p;
        while (n < u + 5) begin
            step();
            if (n < e)      exp = vec(0, 0, m0);
            else if (n < s) exp = vec(1, 0, m0);
            else if (n < u) exp = vec(1, 1, m1);
            else            exp = vec(0, 0, m1);
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL switch c=%0d n=%0d (e=%0d s=%0d u=%0d) got %b want %b",
                         coincide, n, e, s, u, obs, exp);
            end
        end
        exp_mode = m1;
    endtask

    task automatic test_withdraw();
        int         l, t0;
        bit         m0;
        logic [4:0] exp;
        m0    = exp_mode;
        l     = $urandom_range(1, 10);
        vs_on = 1'b0;
        repeat (4) step();
        t0       = n;
        mode_req = ~m0;
        // One vsync rise exactly on the edge where the withdrawal is seen.
        vs_period = 1000;
        vs_base   = t0 + l + 3;
        vs_on     = 1'b1;
        for (int i = 1; i <= l + 12; i++) begin
            exp_q.push_back((i >= 3 && i <= l + 2) ? vec(1, 0, m0) : vec(0, 0, m0));
        end
        while (exp_q.size() > 0) begin
            step();
            if (n == t0 + l) mode_req = m0;
            exp = exp_q.pop_front();
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL withdraw l=%0d n=%0d got %b want %b", l, n, obs, exp);
            end
        end
        vs_on = 1'b0;
    endtask

    task automatic test_watchdog();
        int         t0, e, s, u, p;
        bit         m0, m1;
        logic [4:0] exp;
        m0    = exp_mode;
        m1    = ~m0;
        vs_on = 1'b0;
        repeat (3) step();
        t0       = n;
        mode_req = m1;
        e        = t0 + 3;
        s        = e + WD_SPAN;
        while (n < s + 20) begin
            step();
            if (n < e)      exp = vec(0, 0, m0);
            else if (n < s) exp = vec(1, 0, m0);
            else            exp = vec(1, 1, m1);
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL watchdog n=%0d (e=%0d s=%0d) got %b want %b", n, e, s, obs, exp);
            end
        end
        p = $urandom_range(20, 80);
        vs_restart(p);
        u = vs_base + (MUTE_FRAMES - 1) * p;
        while (n < u + 5) begin
            step();
            exp = (n < u) ? vec(1, 1, m1) : vec(0, 0, m1);
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL watchdog_mute n=%0d (u=%0d) got %b want %b", n, u, obs, exp);
            end
        end
        exp_mode = m1;
    endtask

    task automatic test_mute_retoggle();
        int         p, k, t0, e, s, u, tg, s2, u2;
        bit         m0, m1;
        logic [4:0] exp;
        m0 = exp_mode;
        m1 = ~m0;
        p  = $urandom_range(20, 80);
        vs_restart(p);
        k = $urandom_range(1, p);
        repeat (k) step();
        t0       = n;
        mode_req = m1;
        e        = t0 + 3;
        s        = next_rise(e);
        u        = s + MUTE_FRAMES * p;
        tg       = s + 1 + $urandom_range(0, p - 1);
        s2       = next_rise(u + 1);
        u2       = s2 + MUTE_FRAMES * p;
        while (n < u2 + 5) begin
            step();
            if (n == tg) mode_req = m0;
            if (n < e)       exp = vec(0, 0, m0);
            else if (n < s)  exp = vec(1, 0, m0);
            else if (n < u)  exp = vec(1, 1, m1);
            else if (n == u) exp = vec(0, 0, m1);
            else if (n < s2) exp = vec(1, 0, m1);
            else if (n < u2) exp = vec(1, 1, m0);
            else             exp = vec(0, 0, m0);
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL mute_retoggle n=%0d (s=%0d u=%0d s2=%0d) got %b want %b",
                         n, s, u, s2, obs, exp);
            end
        end
        exp_mode = m0;
    endtask

    task automatic test_reset_midop();
        int         p, stop_at, r1, u0, e, s, u;
        logic [4:0] exp;
        p = $urandom_range(20, 80);
        vs_restart(p);
        mode_req = 1'b1;
        // Land inside the mute of a 0->1 switch, or anywhere in STABLE-1.
        if (exp_mode == 1'b0) stop_at = next_rise(n + 3) + 1 + $urandom_range(0, p - 1);
        else                  stop_at = n + $urandom_range(5, 2 * p);
        while (n < stop_at) step();
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (obs !== vec(1, 1, 0)) begin
            errors++;
            $display("FAIL reset_async n=%0d got %b want %b", n, obs, vec(1, 1, 0));
        end
        repeat (3) begin
            step();
            checks++;
            if (obs !== vec(1, 1, 0)) begin
                errors++;
                $display("FAIL reset_mid_hold n=%0d got %b want %b", n, obs, vec(1, 1, 0));
            end
        end
        while (vs_level(n + 1)) step();
        reset = 1'b0;
        r1 = next_rise(n);
        u0 = r1 + (MUTE_FRAMES - 1) * p;
        e  = u0 + 1;
        s  = next_rise(e);
        u  = s + MUTE_FRAMES * p;
        while (n < u + 5) begin
            step();
            if (n < u0)     exp = vec(1, 1, 0);
            else if (n < e) exp = vec(0, 0, 0);
            else if (n < s) exp = vec(1, 0, 0);
            else if (n < u) exp = vec(1, 1, 1);
            else            exp = vec(0, 0, 1);
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL reset_resume n=%0d (u0=%0d s=%0d u=%0d) got %b want %b",
                         n, u0, s, u, obs, exp);
            end
        end
        exp_mode = 1'b1;
    endtask

`ifdef YPBPR_MODE_CTRL_SOG_EN
    task automatic test_sog();
        int   s, u;
        logic exp;
        // Stable YPbPr: sog is cs_in one clock later.
        repeat (30) begin
            cs_in = 1'($urandom_range(0, 1));
            sog_q.push_back(cs_in);
            step();
            exp = sog_q.pop_front();
            checks++;
            if (sog !== exp) begin
                errors++;
                $display("FAIL sog_follow n=%0d got %b want %b", n, sog, exp);
            end
        end
        // Switch to RGB: sog follows until the switch edge, then stays low.
        mode_req = 1'b0;
        s        = next_rise(n + 3);
        u        = s + MUTE_FRAMES * vs_period;
        while (n < u + 10) begin
            cs_in = 1'($urandom_range(0, 1));
            exp   = (n + 1 <= s) ? cs_in : 1'b0;
            step();
            checks++;
            if (sog !== exp) begin
                errors++;
                $display("FAIL sog_rgb n=%0d got %b want %b", n, sog, exp);
            end
        end
        exp_mode = 1'b0;
    endtask
`endif

    // ---------------------------------------------------------------------
    // Sequence and final report
    // ---------------------------------------------------------------------
    initial begin
        test_reset();
        test_switch(1'b1);
        test_switch(1'b1);
        repeat (3) test_switch(1'b0);
        repeat (3) test_withdraw();
        test_mute_retoggle();
        test_watchdog();
        test_reset_midop();
`ifdef YPBPR_MODE_CTRL_SOG_EN
        test_sog();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
